// File: rtl/lfsr_pkg.sv
// Shared types and constants for the parametrised LFSR generator.
// Includes a lookup of maximal-length tap masks per width.
package lfsr_pkg;

  localparam int LFSR_MAX_WIDTH = 32;

  typedef enum logic {
    LFSR_FIB = 1'b0,
    LFSR_GAL = 1'b1
  } lfsr_mode_e;

  function automatic logic [31:0] max_taps(input int width);
    logic [31:0] t;
    t = 32'h0;
    case (width)
      3:  t = 32'h0000_0006;
      4:  t = 32'h0000_000C;
      5:  t = 32'h0000_0014;
      6:  t = 32'h0000_0030;
      7:  t = 32'h0000_0060;
      8:  t = 32'h0000_00B8;
      9:  t = 32'h0000_0110;
      10: t = 32'h0000_0240;
      11: t = 32'h0000_0500;
      12: t = 32'h0000_0829;
      13: t = 32'h0000_100D;
      14: t = 32'h0000_2015;
      15: t = 32'h0000_6000;
      16: t = 32'h0000_D008;
      17: t = 32'h0001_2000;
      18: t = 32'h0002_0400;
      19: t = 32'h0004_0023;
      20: t = 32'h0009_0000;
      21: t = 32'h0014_0000;
      22: t = 32'h0030_0000;
      23: t = 32'h0042_0000;
      24: t = 32'h00E1_0000;
      25: t = 32'h0120_0000;
      26: t = 32'h0200_0023;
      27: t = 32'h0400_0013;
      28: t = 32'h0900_0000;
      29: t = 32'h1400_0000;
      30: t = 32'h2000_0029;
      31: t = 32'h4800_0000;
      32: t = 32'h8020_0003;
      default: t = 32'h0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state logic for one LFSR step.
// fb_bit is the bit shifted out of the register on this step.
module lfsr_next
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter lfsr_mode_e       MODE  = LFSR_FIB
) (
  input  logic [WIDTH-1:0] state,
  output logic [WIDTH-1:0] nxt,
  output logic             fb_bit
);

  logic fib_in;

  always_comb begin
    fib_in = ^(state & TAPS);
    if (MODE == LFSR_FIB) begin
      fb_bit = state[WIDTH-1];
      nxt    = {state[WIDTH-2:0], fib_in};
    end else begin
      fb_bit = state[0];
      nxt    = (state >> 1)
             ^ ({WIDTH{state[0]}} & TAPS);
    end
  end

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci/Galois LFSR with seed load,
// zero-state recovery and a period-wrap strobe.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter int               MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             wrap,
  output logic             lockup
);

  localparam lfsr_mode_e MD =
    (MODE == 1) ? LFSR_GAL : LFSR_FIB;

  if (WIDTH < 3 || WIDTH > LFSR_MAX_WIDTH)
  begin : g_bad_width
    $error("lfsr_gen: WIDTH out of 3..32");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_gen: SEED must be nonzero");
  end
  if (TAPS == '0) begin : g_bad_taps
    $error("lfsr_gen: TAPS must be nonzero");
  end
  if (TAPS[WIDTH-1] == 1'b0) begin : g_bad_msb
    $error("lfsr_gen: mode %0d needs MSB tap", MODE);
  end

  logic [WIDTH-1:0] seed_reg;
  logic [WIDTH-1:0] nxt;
  logic             fb_bit;

  lfsr_next #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .MODE  (MD)
  ) u_next (
    .state  (state),
    .nxt    (nxt),
    .fb_bit (fb_bit)
  );

  assign bit_out = fb_bit;

  // A zero seed or zero state would freeze the LFSR, so SEED replaces it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= SEED;
      seed_reg <= SEED;
      wrap     <= 1'b0;
      lockup   <= 1'b0;
    end else if (load) begin
      wrap <= 1'b0;
      if (seed_in != '0) begin
        state    <= seed_in;
        seed_reg <= seed_in;
        lockup   <= 1'b0;
      end else begin
        state    <= SEED;
        seed_reg <= SEED;
        lockup   <= 1'b1;
      end
    end else if (en) begin
      if (state == '0) begin
        state  <= SEED;
        wrap   <= 1'b0;
        lockup <= 1'b1;
      end else begin
        state  <= nxt;
        wrap   <= (nxt == seed_reg);
        lockup <= 1'b0;
      end
    end else begin
      wrap   <= 1'b0;
      lockup <= 1'b0;
    end
  end

endmodule
